// File: rtl/hh_current_scheduler_if.sv
// Scheduler bundle: step control, V read port, compute-unit handshake and I_ion write port.
// master = scheduler side, slave = neuron memories / compute unit / step controller side.
interface hh_current_scheduler_if #(
    parameter int IDX_W = 2
);
    logic                    step_start;
    logic [15:0]             dt;
    logic                    busy;
    logic                    step_done;
    logic [IDX_W-1:0]        v_addr;
    logic signed [15:0]      v_data;
    logic                    cu_start;
    logic [1:0]              cu_sel;
    logic signed [15:0]      cu_V;
    logic [15:0]             cu_dt;
    logic                    cu_done;
    logic signed [15:0]      cu_I;
    logic                    i_we;
    logic [IDX_W-1:0]        i_addr;
    logic signed [15:0]      i_data;
    logic                    err_timeout;

    modport master (
        input  step_start, dt, v_data, cu_done, cu_I,
        output busy, step_done, v_addr, cu_start, cu_sel, cu_V, cu_dt,
               i_we, i_addr, i_data, err_timeout
    );

    modport slave (
        output step_start, dt, v_data, cu_done, cu_I,
        input  busy, step_done, v_addr, cu_start, cu_sel, cu_V, cu_dt,
               i_we, i_addr, i_data, err_timeout
    );
endinterface

// File: rtl/hh_current_scheduler.sv
// Shares one ion-current compute unit across all neurons each timestep, summing channel currents
// with saturation. Optional WAIT watchdog is enabled by defining SCHED_TIMEOUT_EN.
module hh_current_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_CH      = 3,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    hh_current_scheduler_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WRITE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_N  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [1:0]       LAST_CH = 2'(NUM_CH - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   n_reg;
    logic [1:0]         ch_reg;
    logic signed [15:0] acc_reg;
    logic signed [15:0] cu_v_reg;
    logic [15:0]        cu_dt_reg;
    logic               busy_reg;
    logic               step_done_reg;
    logic               cu_start_reg;
    logic               i_we_reg;
    logic signed [15:0] i_data_reg;

    logic [16:0]        sum_next;
    logic signed [15:0] sat_next;
    logic signed [15:0] acc_next;
    logic               wait_exp;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_reg;
    logic          err_reg;
    assign wait_exp        = !bus.cu_done && (wait_cnt_reg == TW'(TIMEOUT - 1));
    assign bus.err_timeout = err_reg;
`else
    assign wait_exp        = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    // 17-bit sum overflows 16 bits exactly when its top two bits differ.
    always_comb begin
        sum_next = {acc_reg[15], acc_reg} + {bus.cu_I[15], bus.cu_I};
        if (sum_next[16] != sum_next[15])
            sat_next = sum_next[16] ? 16'sh8000 : 16'sh7fff;
        else
            sat_next = sum_next[15:0];
        acc_next = bus.cu_done ? sat_next : acc_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            n_reg         <= '0;
            ch_reg        <= '0;
            acc_reg       <= '0;
            cu_v_reg      <= '0;
            cu_dt_reg     <= '0;
            busy_reg      <= 1'b0;
            step_done_reg <= 1'b0;
            cu_start_reg  <= 1'b0;
            i_we_reg      <= 1'b0;
            i_data_reg    <= '0;
`ifdef SCHED_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.step_start) begin
                        n_reg     <= '0;
                        cu_dt_reg <= bus.dt;
                        busy_reg  <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    cu_v_reg     <= bus.v_data;
                    acc_reg      <= '0;
                    ch_reg       <= '0;
                    cu_start_reg <= 1'b1;
                    state_reg    <= ISSUE;
                end
                ISSUE: begin
                    cu_start_reg <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    acc_reg <= acc_next;
`ifdef SCHED_TIMEOUT_EN
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    if (wait_exp)
                        err_reg <= 1'b1;
`endif
                    // A timed-out channel advances with acc unchanged, i.e. contributes 0.
                    if (bus.cu_done || wait_exp) begin
                        if (ch_reg < LAST_CH) begin
                            ch_reg       <= ch_reg + 2'd1;
                            cu_start_reg <= 1'b1;
                            state_reg    <= ISSUE;
                        end else begin
                            i_we_reg   <= 1'b1;
                            i_data_reg <= acc_next;
                            state_reg  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    i_we_reg <= 1'b0;
                    if (n_reg < LAST_N) begin
                        n_reg     <= n_reg + 1'b1;
                        state_reg <= FETCH;
                    end else begin
                        step_done_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    step_done_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.step_done = step_done_reg;
    assign bus.v_addr    = n_reg;
    assign bus.cu_start  = cu_start_reg;
    assign bus.cu_sel    = ch_reg;
    assign bus.cu_V      = cu_v_reg;
    assign bus.cu_dt     = cu_dt_reg;
    assign bus.i_we      = i_we_reg;
    assign bus.i_addr    = n_reg;
    assign bus.i_data    = i_data_reg;
endmodule
